mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the 32-bit MIPS datapath. Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in the architectural HI and LO registers. Supports MTHI and MTLO writes. The hi and lo outputs feed the 32-bit 2:1 result-select mux, which is driven by MFHI/MFLO, ahead of register-file writeback.

---
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with sign handling wrapped around an unsigned magnitude core, plus MTHI/MTLO writes.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               is_div, is_div_next;
  logic               a_neg, a_neg_next;
  logic               b_neg, b_neg_next;
  logic               b_zero, b_zero_next;
  logic [WIDTH-1:0]   a_raw, a_raw_next;
  logic [WIDTH-1:0]   opnd, opnd_next;
  logic [WIDTH-1:0]   acc_hi, acc_hi_next;
  logic [WIDTH-1:0]   acc_lo, acc_lo_next;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic               busy_next, done_next;

  // Operand magnitudes; only the signed ops (op[0]=1) strip the sign
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (op[0] && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (op[0] && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // One multiply step: conditionally add the multiplicand into the upper half
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // One restoring divide step: shift in the next dividend bit and trial-subtract
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

  // Sign-corrected final results
  logic [PROD_W-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (a_neg ^ b_neg) ? (~prod + PROD_W'(1)) : prod;
  assign quo_fix  = (a_neg ^ b_neg) ? (~acc_lo + WIDTH'(1)) : acc_lo;
  assign rem_fix  = a_neg ? (~acc_hi + WIDTH'(1)) : acc_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      is_div <= is_div_next;
      a_neg  <= a_neg_next;
      b_neg  <= b_neg_next;
      b_zero <= b_zero_next;
      a_raw  <= a_raw_next;
      opnd   <= opnd_next;
      acc_hi <= acc_hi_next;
      acc_lo <= acc_lo_next;
      hi     <= hi_next;
      lo     <= lo_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    is_div_next = is_div;
    a_neg_next  = a_neg;
    b_neg_next  = b_neg;
    b_zero_next = b_zero;
    a_raw_next  = a_raw;
    opnd_next   = opnd;
    acc_hi_next = acc_hi;
    acc_lo_next = acc_lo;
    hi_next     = hi;
    lo_next     = lo;
    busy_next   = busy;
    done_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (hi_we) hi_next = wdata;
        if (lo_we) lo_next = wdata;
        if (start) begin
          is_div_next = op[1];
          a_neg_next  = op[0] & a[WIDTH-1];
          b_neg_next  = op[0] & b[WIDTH-1];
          b_zero_next = (b == '0);
          a_raw_next  = a;
          opnd_next   = b_mag;
          acc_hi_next = '0;
          acc_lo_next = a_mag;
          cnt_next    = '0;
          busy_next   = 1'b1;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (is_div) begin
          acc_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_next = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
          {acc_hi_next, acc_lo_next} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) state_next = FINISH;
      end

      FINISH: begin
        if (!is_div) begin
          {hi_next, lo_next} = prod_fix;
        end else if (b_zero) begin
          // Divide by zero: all-ones quotient, dividend passed through untouched
          hi_next = a_raw;
          lo_next = '1;
        end else begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed and random ops checked against a
// plain-arithmetic reference, plus handshake, MTHI/MTLO and reset checks.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  bit          done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: MIPS semantics from plain 64-bit arithmetic, result as {hi, lo}
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return {32'd0, x} * {32'd0, y};
      2'd1: return 64'(sx * sy);
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) check("done_pulse_width", done, 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: hi=%h lo=%h with no pending op (cycle %0d)", hi, lo, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("hi", hi, mon_e.hi);
          check("lo", lo, mon_e.lo);
          check("latency", cyc, mon_e.due);
          check("busy_at_done", busy, 0);
          model_hi = mon_e.hi;
          model_lo = mon_e.lo;
        end
      end
      done_prev = done;
    end
  end

  // Called at a negedge; returns at the negedge after the start edge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit accept, input logic [63:0] r);
    exp_t e;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (accept) begin
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.due = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_busy);
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      if (chk_busy) check("busy_run", busy, 1);
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: done not seen within 40 cycles (cycle %0d)", cyc);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] r;
  } vec_t;

  vec_t dir[$];

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU all-ones with busy tracked every cycle
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    wait_done(1'b1);
    @(negedge clk);

    dir.push_back('{2'd1, 32'hFFFF_FFFD, 32'd7,          64'hFFFF_FFFF_FFFF_FFEB});
    dir.push_back('{2'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    dir.push_back('{2'd2, 32'd100,       32'd7,          64'h0000_0002_0000_000E});
    dir.push_back('{2'd3, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD});
    dir.push_back('{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
    dir.push_back('{2'd2, 32'h1234_5678, 32'd0,          64'h1234_5678_FFFF_FFFF});
    dir.push_back('{2'd3, 32'hFFFF_FFF9, 32'd0,          64'hFFFF_FFF9_FFFF_FFFF});
    dir.push_back('{2'd3, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
    dir.push_back('{2'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002});
    dir.push_back('{2'd1, 32'd0,         32'h0001_2345, 64'h0});
    foreach (dir[i]) begin
      issue(dir[i].o, dir[i].x, dir[i].y, 1'b1, dir[i].r);
      wait_done(1'b0);
      @(negedge clk);
    end

    // start while busy is ignored; start in the done cycle is accepted
    issue(2'd0, 32'd2, 32'd3, 1'b1, 64'd6);
    repeat (9) @(negedge clk);
    issue(2'd0, 32'd5, 32'd5, 1'b0, 64'd0);
    wait_done(1'b0);
    issue(2'd0, 32'd5, 32'd5, 1'b1, 64'd25);
    wait_done(1'b0);
    @(negedge clk);

    // MTHI while idle, then MTHI/MTLO while busy are dropped
    hi_we = 1'b1;
    wdata = 32'hCAFE_BABE;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hCAFE_BABE);
    check("lo_kept", lo, model_lo);
    issue(2'd2, 32'd9, 32'd2, 1'b1, {32'd1, 32'd4});
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mtlo_busy", lo, 32'd25);
    check("mthi_busy", hi, 32'hCAFE_BABE);
    wait_done(1'b0);
    @(negedge clk);

    // Writes together with start land at the start edge, then get overwritten
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h5A5A_5A5A;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi_with_start", hi, 32'h5A5A_5A5A);
    check("mtlo_with_start", lo, 32'h5A5A_5A5A);
    wait_done(1'b0);
    @(negedge clk);

    // Randomized ops with biased corner operands
    repeat (30) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       x = 32'h8000_0000;
        1:       x = 32'($urandom_range(0, 20));
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      issue(o, x, y, 1'b1, ref_op(o, x, y));
      wait_done(1'b0);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    // Reset in the middle of a MULT: no result and no done pulse
    issue(2'd1, 32'h0001_2345, 32'hFFFF_0000, 1'b1, ref_op(2'd1, 32'h0001_2345, 32'hFFFF_0000));
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (45) @(negedge clk);
    issue(2'd2, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3});
    wait_done(1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
